// File: rtl/padframe_cfg_loader_pkg.sv
// -----------------------------------------------------------------------------
// padframe_cfg_loader_pkg
// Shared types and constants for the boot-time padframe configuration loader:
// the two-state controller enum, the table index width, and the default
// register-bus request/response structs used when the instantiating design
// does not supply its own.
// -----------------------------------------------------------------------------
package padframe_cfg_loader_pkg;

  // Controller states: replaying the boot table, or passing the host through.
  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } state_e;

  // Width of the table index and of the reported error index.
  localparam int unsigned IdxW = 8;

  // Default register bus geometry.
  localparam int unsigned RegAw = 32;
  localparam int unsigned RegDw = 32;

  typedef struct packed {
    logic [RegAw-1:0]   addr;
    logic               write;
    logic [RegDw-1:0]   wdata;
    logic [RegDw/8-1:0] wstrb;
    logic               valid;
  } reg_req_t;

  typedef struct packed {
    logic [RegDw-1:0] rdata;
    logic             error;
    logic             ready;
  } reg_rsp_t;

endpackage

// File: rtl/padframe_cfg_loader.sv
// -----------------------------------------------------------------------------
// padframe_cfg_loader
// After reset (and on request) writes a fixed table of configuration values
// into the padframe config port, then hands the port to software.
//
// Ports
//   clk_i       sole clock, rising edge
//   rst_ni      asynchronous active-low reset
//   host_req_i  software config request (stalled while the table replays)
//   host_rsp_o  software config response
//   pad_req_o   request to the padframe config port
//   pad_rsp_i   response from the padframe config port
//   restart_i   single-cycle pulse: replay the table (honoured only in DONE)
//   busy_o      table replay in progress
//   done_o      table finished, host connected to the padframe
//   error_o     sticky: a table write returned error
//   err_idx_o   index of the first table entry that returned error
// -----------------------------------------------------------------------------
module padframe_cfg_loader
  import padframe_cfg_loader_pkg::*;
#(
  parameter int unsigned NumEntries = 4,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter type         req_t      = reg_req_t,
  parameter type         rsp_t      = reg_rsp_t,
  // Tables keep at least one slot so an empty table still elaborates.
  parameter logic [((NumEntries > 0) ? NumEntries : 1)-1:0][AW-1:0] InitAddr = '0,
  parameter logic [((NumEntries > 0) ? NumEntries : 1)-1:0][DW-1:0] InitData = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  req_t            host_req_i,
  output rsp_t            host_rsp_o,
  output req_t            pad_req_o,
  input  rsp_t            pad_rsp_i,
  input  logic            restart_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic [IdxW-1:0] err_idx_o
);

  localparam int unsigned TblLen  = (NumEntries > 0) ? NumEntries : 1;
  localparam int unsigned SelW    = (TblLen > 1) ? $clog2(TblLen) : 1;
  localparam logic [IdxW-1:0] LastIdx =
    (NumEntries > 0) ? IdxW'(NumEntries - 1) : '0;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic            error_q;
  logic [IdxW-1:0] err_idx_q;
  logic [SelW-1:0] sel;
  logic            xfer;

  assign sel  = idx_q[SelW-1:0];
  assign xfer = pad_req_o.valid && pad_rsp_i.ready;

  // Port muxing. In DONE the host sees the padframe with zero latency; in LOAD
  // the table entry owns the port and the host is held off with ready=0 so its
  // request stays pending rather than being dropped.
  // NOTE: every output gets a full default first so no path leaves it
  // unassigned -- that is what keeps this block from inferring latches.
  always_comb begin
    pad_req_o  = host_req_i;
    host_rsp_o = pad_rsp_i;
    if (state_q == LOAD) begin
      pad_req_o       = '0;
      pad_req_o.valid = 1'b1;
      pad_req_o.write = 1'b1;
      pad_req_o.addr  = InitAddr[sel];
      pad_req_o.wdata = InitData[sel];
      pad_req_o.wstrb = '1;
      host_rsp_o      = '0;
    end
    // Nothing may reach the padframe while reset is held; the first request
    // appears in the cycle right after release.
    if (!rst_ni) begin
      pad_req_o.valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= (NumEntries > 0) ? LOAD : DONE;
      idx_q     <= '0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (xfer) begin
            // Only the first failing entry is recorded; the replay carries on.
            if (pad_rsp_i.error && !error_q) begin
              error_q   <= 1'b1;
              err_idx_q <= idx_q;
            end
            if (idx_q == LastIdx) begin
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          // A host transfer in this same cycle still completes through the
          // pass-through; the switch back to LOAD lands on the next edge.
          if (restart_i && (NumEntries > 0)) begin
            state_q   <= LOAD;
            idx_q     <= '0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
          end
        end
        default: state_q <= DONE;
      endcase
    end
  end

  assign busy_o    = (state_q == LOAD);
  assign done_o    = (state_q == DONE);
  assign error_o   = error_q;
  assign err_idx_o = err_idx_q;

endmodule

// File: tb/tb_padframe_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_padframe_cfg_loader
// Directed bench for padframe_cfg_loader with a three-entry table.
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit
// later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_padframe_cfg_loader;
  import padframe_cfg_loader_pkg::*;

  localparam int unsigned N = 3;
  localparam logic [N-1:0][31:0] TblAddr = {32'h0000_0018, 32'h0000_0014, 32'h0000_0010};
  localparam logic [N-1:0][31:0] TblData = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};

  logic            clk;
  logic            rst_n;
  reg_req_t        host_req;
  reg_rsp_t        host_rsp;
  reg_req_t        pad_req;
  reg_rsp_t        pad_rsp;
  logic            restart;
  logic            busy;
  logic            done;
  logic            error;
  logic [IdxW-1:0] err_idx;

  int checks = 0;
  int errors = 0;

  padframe_cfg_loader #(
    .NumEntries (N),
    .AW         (32),
    .DW         (32),
    .req_t      (reg_req_t),
    .rsp_t      (reg_rsp_t),
    .InitAddr   (TblAddr),
    .InitData   (TblData)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .host_req_i (host_req),
    .host_rsp_o (host_rsp),
    .pad_req_o  (pad_req),
    .pad_rsp_i  (pad_rsp),
    .restart_i  (restart),
    .busy_o     (busy),
    .done_o     (done),
    .error_o    (error),
    .err_idx_o  (err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Table entry k must be on the padframe port with a full write.
  task automatic chk_entry(input string tag, input int k);
    #1;
    chk({tag, ".valid"}, 64'(pad_req.valid), 64'd1);
    chk({tag, ".write"}, 64'(pad_req.write), 64'd1);
    chk({tag, ".addr"},  64'(pad_req.addr),  64'(TblAddr[k]));
    chk({tag, ".wdata"}, 64'(pad_req.wdata), 64'(TblData[k]));
    chk({tag, ".wstrb"}, 64'(pad_req.wstrb), 64'hF);
    chk({tag, ".busy"},  64'(busy), 64'd1);
    chk({tag, ".done"},  64'(done), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    restart  = 1'b0;
    host_req = '0;
    pad_rsp  = '0;
    pad_rsp.ready = 1'b1;
    pad_rsp.rdata = 32'h0000_0055;

    // Reset state.
    #2;
    chk("rst.valid",   64'(pad_req.valid), 64'd0);
    chk("rst.error",   64'(error),   64'd0);
    chk("rst.err_idx", 64'(err_idx), 64'd0);
    chk("rst.busy",    64'(busy),    64'd1);
    chk("rst.done",    64'(done),    64'd0);

    // Host write to the gpio0 mux offset is posted during the replay.
    host_req.valid = 1'b1;
    host_req.write = 1'b1;
    host_req.addr  = 32'h0000_0040;
    host_req.wdata = 32'h0000_0002;
    host_req.wstrb = 4'hF;

    // Release between edges; entry 0 must be on the port immediately.
    #10;
    rst_n = 1'b1;
    chk_entry("nom.e0", 0);
    chk("nom.e0.host_ready", 64'(host_rsp.ready), 64'd0);
    chk("nom.e0.host_rdata", 64'(host_rsp.rdata), 64'd0);
    tick();
    chk_entry("nom.e1", 1);
    chk("nom.e1.host_ready", 64'(host_rsp.ready), 64'd0);
    tick();
    chk_entry("nom.e2", 2);
    chk("nom.e2.host_ready", 64'(host_rsp.ready), 64'd0);
    tick();
    #1;
    chk("nom.done",  64'(done),  64'd1);
    chk("nom.busy",  64'(busy),  64'd0);
    chk("nom.error", 64'(error), 64'd0);
    // Host now passes straight through and completes this cycle.
    chk("host.pad_valid", 64'(pad_req.valid), 64'd1);
    chk("host.pad_addr",  64'(pad_req.addr),  64'h40);
    chk("host.pad_wdata", 64'(pad_req.wdata), 64'h2);
    chk("host.ready",     64'(host_rsp.ready), 64'd1);
    chk("host.rdata",     64'(host_rsp.rdata), 64'h55);
    tick();
    host_req = '0;

    // Replay with errors on entries 1 and 2.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk_entry("err.e0", 0);
    tick();
    pad_rsp.error = 1'b1;
    chk_entry("err.e1", 1);
    chk("err.e1.error", 64'(error), 64'd0);
    tick();
    chk_entry("err.e2", 2);
    chk("err.e2.error",   64'(error),   64'd1);
    chk("err.e2.err_idx", 64'(err_idx), 64'd1);
    tick();
    pad_rsp.error = 1'b0;
    #1;
    chk("err.done",    64'(done),    64'd1);
    chk("err.error",   64'(error),   64'd1);
    chk("err.err_idx", 64'(err_idx), 64'd1);

    // Restart together with a host write: the write completes this cycle.
    #1;
    host_req.valid = 1'b1;
    host_req.write = 1'b1;
    host_req.addr  = 32'h0000_0044;
    host_req.wdata = 32'h0000_0003;
    host_req.wstrb = 4'hF;
    restart = 1'b1;
    #1;
    chk("rs.pad_valid",  64'(pad_req.valid),  64'd1);
    chk("rs.pad_addr",   64'(pad_req.addr),   64'h44);
    chk("rs.host_ready", 64'(host_rsp.ready), 64'd1);
    tick();
    restart  = 1'b0;
    host_req = '0;
    chk_entry("rs.e0", 0);
    chk("rs.error",   64'(error),   64'd0);
    chk("rs.err_idx", 64'(err_idx), 64'd0);

    // Stall entry 1 for five cycles; a restart pulse mid-replay is ignored.
    tick();
    pad_rsp.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      restart = (i == 2);
      chk_entry($sformatf("stall.%0d", i), 1);
      tick();
    end
    restart = 1'b0;
    pad_rsp.ready = 1'b1;
    chk_entry("stall.5", 1);
    tick();
    chk_entry("stall.next", 2);
    tick();
    #1;
    chk("stall.done", 64'(done), 64'd1);

    // Reset asserted with entry 1 outstanding.
    #1;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk_entry("ar.e0", 0);
    tick();
    chk_entry("ar.e1", 1);
    rst_n = 1'b0;
    #1;
    chk("ar.valid", 64'(pad_req.valid), 64'd0);
    chk("ar.busy",  64'(busy), 64'd1);
    tick();
    rst_n = 1'b1;
    chk_entry("ar.restart_e0", 0);
    tick();
    chk_entry("ar.restart_e1", 1);
    tick();
    chk_entry("ar.restart_e2", 2);
    tick();
    #1;
    chk("ar.done",  64'(done),  64'd1);
    chk("ar.error", 64'(error), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
